// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA colour type, 640x480@60 timing defaults and axis period helper
package vga_pkg;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: framebuffer read port plus VGA pin bundle
interface vga_timing_gen_if import vga_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int FRAME_W  = 16
);
  logic                        en;
  logic [$clog2(H_ACTIVE)-1:0] pix_x;
  logic [$clog2(V_ACTIVE)-1:0] pix_y;
  logic                        pix_req;
  rgb332_t                     pix_data;
  logic                        hsync;
  logic                        vsync;
  logic [2:0]                  VGA_R;
  logic [2:0]                  VGA_G;
  logic [1:0]                  VGA_B;
  logic                        frame_start;
  logic [FRAME_W-1:0]          frame_count;
  modport master (
    input  en, pix_data,
    output pix_x, pix_y, pix_req, hsync, vsync, VGA_R, VGA_G, VGA_B, frame_start, frame_count
  );
  modport slave (
    output en, pix_data,
    input  pix_x, pix_y, pix_req, hsync, vsync, VGA_R, VGA_G, VGA_B, frame_start, frame_count
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter for one VGA axis with active/sync region decodes
module vga_axis_counter import vga_pkg::*; #(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  localparam int TOT   = axis_total(ACTIVE, FP, SYNC, BP),
  localparam int W     = $clog2(TOT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         step_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         in_active_o,
  output logic         in_sync_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // next count: clear wins, otherwise step and wrap after TOT-1
  always_comb begin
    wrap_o = step_i && cnt_q == W'(TOT - 1);
    cnt_d  = clr_i || wrap_o ? '0 : step_i ? cnt_q + W'(1) : cnt_q;
  end
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o       = cnt_q;
  assign in_active_o = int'(cnt_q) < ACTIVE;
  assign in_sync_o   = int'(cnt_q) >= ACTIVE + FP && int'(cnt_q) < ACTIVE + FP + SYNC;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA counters, read-latency-matched sync/colour pipeline and frame counter
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int RD_LAT   = 2,
  parameter int FRAME_W  = 16
) (
  input logic              CLK,
  input logic              reset,
  vga_timing_gen_if.master vif
);
  localparam int HW = $clog2(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW = $clog2(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int PW = 3 * RD_LAT;
  logic [DW-1:0]      div_q, div_d;
  logic [PW-1:0]      pipe_q, pipe_d;
  logic               hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  rgb332_t            rgb_q, rgb_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic               tick, visible, h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(CLK), .rst_n(reset), .clr_i(!vif.en), .step_i(tick),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .in_active_o(h_act), .in_sync_o(h_sync)
  );
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(CLK), .rst_n(reset), .clr_i(!vif.en), .step_i(h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .in_active_o(v_act), .in_sync_o(v_sync)
  );
  // pixel tick, pipeline shift and pin next-state; the pipeline top holds {visible, hsync, vsync} from RD_LAT ticks ago
  always_comb begin
    tick    = vif.en && div_q == DW'(CLK_DIV - 1);
    visible = h_act && v_act;
    div_d   = !vif.en || tick ? '0 : div_q + DW'(1);
    pipe_d  = !vif.en ? '0 : tick ? PW'({pipe_q, visible, h_sync, v_sync}) : pipe_q;
    hs_d    = !vif.en ? ~H_POL : tick ? (pipe_q[PW-2] ? H_POL : ~H_POL) : hs_q;
    vs_d    = !vif.en ? ~V_POL : tick ? (pipe_q[PW-3] ? V_POL : ~V_POL) : vs_q;
    rgb_d   = !vif.en ? '0 : tick ? (pipe_q[PW-1] ? vif.pix_data : '0) : rgb_q;
    fs_d    = v_wrap;
    fc_d    = fc_q + FRAME_W'(v_wrap);
  end
  // state registers; reset puts the pins at inactive sync and black
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      div_q  <= '0;
      pipe_q <= '0;
      hs_q   <= ~H_POL;
      vs_q   <= ~V_POL;
      rgb_q  <= '0;
      fs_q   <= 1'b0;
      fc_q   <= '0;
    end else begin
      div_q  <= div_d;
      pipe_q <= pipe_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      rgb_q  <= rgb_d;
      fs_q   <= fs_d;
      fc_q   <= fc_d;
    end
  assign vif.pix_x       = visible ? XW'(h_cnt) : '0;
  assign vif.pix_y       = visible ? YW'(v_cnt) : '0;
  assign vif.pix_req     = tick && visible;
  assign vif.hsync       = hs_q;
  assign vif.vsync       = vs_q;
  assign vif.VGA_R       = rgb_q.r;
  assign vif.VGA_G       = rgb_q.g;
  assign vif.VGA_B       = rgb_q.b;
  assign vif.frame_start = fs_q;
  assign vif.frame_count = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-geometry checks against a tick-count reference model
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 1, VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FRAME = HT * VT;
  localparam int DIV = 2, LAT = 2;
  typedef struct packed {
    logic       req;
    logic [2:0] x;
    logic [1:0] y;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
    logic       fs;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  int   tests = 0, fails = 0;
  int   n, fc;
  logic [8:0] slot [LAT];
  logic [7:0] junk, fb_data;
  always #5 clk = ~clk;
  vga_timing_gen_if #(.H_ACTIVE(HA), .V_ACTIVE(VA), .FRAME_W(16)) if0 ();
  vga_timing_gen_if #(.H_ACTIVE(HA), .V_ACTIVE(VA), .FRAME_W(2)) if1 ();
  assign if0.en = en;
  assign if1.en = en;
  assign fb_data = slot[LAT-1][8] ? slot[LAT-1][7:0] : junk;
  assign if0.pix_data = fb_data;
  assign if1.pix_data = fb_data;
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(DIV), .RD_LAT(LAT), .FRAME_W(16))
    dut0 (.CLK(clk), .reset(rst_n), .vif(if0.master));
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(DIV), .RD_LAT(LAT), .FRAME_W(2))
    dut1 (.CLK(clk), .reset(rst_n), .vif(if1.master));
  // reference: n = enabled clocks since last reset/disable, fc = completed frames
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n  <= 0;
      fc <= 0;
    end else if (!en) n <= 0;
    else begin
      n <= n + 1;
      if ((n + 1) % DIV == 0 && ((n + 1) / DIV) % FRAME == 0) fc <= fc + 1;
    end
  // framebuffer: answers each request LAT ticks later, junk (often 8'hFF) otherwise
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) slot[i] <= '0;
      junk <= 8'hFF;
    end else begin
      junk <= ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      if (!en) for (int i = 0; i < LAT; i++) slot[i] <= '0;
      else if (n % DIV == DIV - 1) begin
        slot[0] <= if0.pix_req ? {1'b1, 3'(if0.pix_y), 5'(if0.pix_x)} : 9'h0;
        for (int i = 1; i < LAT; i++) slot[i] <= slot[i-1];
      end
    end
  // expected observation: counters sit at tick count nn/DIV, pins show the position LAT+1 ticks older
  function automatic obs_t model(int nn, logic e);
    obs_t r;
    int p, h, v, q, qh, qv;
    p = (nn / DIV) % FRAME;
    h = p % HT;
    v = p / HT;
    r.req = e && nn % DIV == DIV - 1 && h < HA && v < VA;
    r.x = (h < HA && v < VA) ? 3'(h) : 3'd0;
    r.y = (h < HA && v < VA) ? 2'(v) : 2'd0;
    q = nn / DIV - 1 - LAT;
    if (q < 0) begin
      r.hs = 1'b1;
      r.vs = 1'b1;
      r.rgb = 8'h00;
    end else begin
      qh = (q % FRAME) % HT;
      qv = (q % FRAME) / HT;
      r.hs = !(qh >= HA + HF && qh < HA + HF + HS);
      r.vs = !(qv >= VA + VF && qv < VA + VF + VS);
      r.rgb = (qh < HA && qv < VA) ? {3'(qv), 5'(qh)} : 8'h00;
    end
    r.fs = nn > 0 && nn % DIV == 0 && (nn / DIV) % FRAME == 0;
    return r;
  endfunction

  task automatic test_reset;
    en = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({if0.hsync, if0.vsync} !== 2'b11) begin fails++; $display("FAIL reset_sync_pol0 got %b want 11", {if0.hsync, if0.vsync}); end
    tests++; if ({if1.hsync, if1.vsync} !== 2'b00) begin fails++; $display("FAIL reset_sync_pol1 got %b want 00", {if1.hsync, if1.vsync}); end
    tests++; if ({if0.VGA_R, if0.VGA_G, if0.VGA_B} !== 8'h00) begin fails++; $display("FAIL reset_rgb got %h want 00", {if0.VGA_R, if0.VGA_G, if0.VGA_B}); end
    tests++; if ({if0.pix_req, if0.frame_start} !== 2'b00) begin fails++; $display("FAIL reset_pulses got %b want 00", {if0.pix_req, if0.frame_start}); end
    tests++; if (if0.frame_count !== 16'd0 || if1.frame_count !== 2'd0) begin fails++; $display("FAIL reset_frame_count got %0d/%0d want 0/0", if0.frame_count, if1.frame_count); end
  endtask

  task automatic test_frame;
    int cnt, hl0, vl0, hh1, vh1, req, bad, p;
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!if0.frame_start && cnt < 1000);
    tests++; if (cnt != 224) begin fails++; $display("FAIL first_frame_start got clk %0d want 224", cnt); end
    tests++; if (if0.frame_count !== 16'd1) begin fails++; $display("FAIL frame_count_1 got %0d want 1", if0.frame_count); end
    {hl0, vl0, hh1, vh1, req, bad} = '0;
    repeat (224) begin
      @(negedge clk);
      p = (n / DIV) % FRAME;
      hl0 += int'(if0.hsync === 1'b0);
      vl0 += int'(if0.vsync === 1'b0);
      hh1 += int'(if1.hsync === 1'b1);
      vh1 += int'(if1.vsync === 1'b1);
      req += int'(if0.pix_req === 1'b1);
      bad += int'(if0.pix_req === 1'b1 && (p % HT >= HA || p / HT >= VA));
    end
    tests++; if (hl0 != 48) begin fails++; $display("FAIL hsync_low_clk got %0d want 48", hl0); end
    tests++; if (vl0 != 56) begin fails++; $display("FAIL vsync_low_clk got %0d want 56", vl0); end
    tests++; if (hh1 != 48 || vh1 != 56) begin fails++; $display("FAIL inverted_sync_clk got %0d/%0d want 48/56", hh1, vh1); end
    tests++; if (req != 32) begin fails++; $display("FAIL pix_req_per_frame got %0d want 32", req); end
    tests++; if (bad != 0) begin fails++; $display("FAIL pix_req_in_blank got %0d want 0", bad); end
    tests++; if (if0.frame_start !== 1'b1 || if0.frame_count !== 16'd2) begin fails++; $display("FAIL second_frame got fs=%b fc=%0d want 1/2", if0.frame_start, if0.frame_count); end
  endtask

  task automatic test_en_toggle;
    int cnt, saved, fs;
    cnt = 0;
    while (!((n / DIV) % FRAME == 2 * HT + 5 && n % DIV == 0) && cnt < 1000) begin @(negedge clk); cnt++; end
    tests++; if (cnt >= 1000) begin fails++; $display("FAIL reach_h5_v2 got timeout want position (5,2)"); end
    saved = fc;
    en = 1'b0;
    #1;
    tests++; if (if0.pix_req !== 1'b0) begin fails++; $display("FAIL en_low_req got %b want 0", if0.pix_req); end
    @(posedge clk) #1;
    tests++; if ({if0.hsync, if0.vsync, if1.hsync, if1.vsync} !== 4'b1100) begin fails++; $display("FAIL en_low_sync got %b want 1100", {if0.hsync, if0.vsync, if1.hsync, if1.vsync}); end
    tests++; if ({if0.VGA_R, if0.VGA_G, if0.VGA_B} !== 8'h00) begin fails++; $display("FAIL en_low_rgb got %h want 00", {if0.VGA_R, if0.VGA_G, if0.VGA_B}); end
    tests++; if (if0.frame_count !== 16'(saved)) begin fails++; $display("FAIL en_low_fc got %0d want %0d", if0.frame_count, saved); end
    repeat ($urandom_range(1, 20)) @(negedge clk);
    en = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!if0.pix_req && cnt < 20);
    tests++; if (cnt != DIV - 1) begin fails++; $display("FAIL reenable_first_req got clk %0d want %0d", cnt, DIV - 1); end
    tests++; if ({if0.pix_x, if0.pix_y} !== 5'd0) begin fails++; $display("FAIL reenable_origin got x=%0d y=%0d want 0 0", if0.pix_x, if0.pix_y); end
    fs = 0;
    repeat (30) begin @(negedge clk); fs += int'(if0.frame_start === 1'b1); end
    tests++; if (fs != 0 || if0.frame_count !== 16'(saved)) begin fails++; $display("FAIL reenable_no_frame_start got fs=%0d fc=%0d want 0/%0d", fs, if0.frame_count, saved); end
  endtask

  task automatic test_random;
    obs_t e0, e1, g0, g1;
    repeat (3000) begin
      @(negedge clk);
      if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      else if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      #1;
      e0 = model(n, en);
      e1 = e0;
      e1.hs = ~e0.hs;
      e1.vs = ~e0.vs;
      g0 = {if0.pix_req, if0.pix_x, if0.pix_y, if0.hsync, if0.vsync, if0.VGA_R, if0.VGA_G, if0.VGA_B, if0.frame_start};
      g1 = {if1.pix_req, if1.pix_x, if1.pix_y, if1.hsync, if1.vsync, if1.VGA_R, if1.VGA_G, if1.VGA_B, if1.frame_start};
      tests++; if (g0 !== e0) begin fails++; $display("FAIL rand_dut0 n=%0d got %h want %h", n, g0, e0); end
      tests++; if (g1 !== e1) begin fails++; $display("FAIL rand_dut1 n=%0d got %h want %h", n, g1, e1); end
      tests++; if (if0.frame_count !== 16'(fc) || if1.frame_count !== 2'(fc)) begin fails++; $display("FAIL rand_fc got %0d/%0d want %0d/%0d", if0.frame_count, if1.frame_count, 16'(fc), 2'(fc)); end
    end
  endtask

  task automatic test_async_reset;
    int cnt, starts;
    en = 1'b1;
    repeat ($urandom_range(50, 150)) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++; if ({if0.hsync, if0.vsync, if1.hsync, if1.vsync} !== 4'b1100) begin fails++; $display("FAIL async_rst_sync got %b want 1100", {if0.hsync, if0.vsync, if1.hsync, if1.vsync}); end
    tests++; if ({if0.VGA_R, if0.VGA_G, if0.VGA_B, if0.pix_req, if0.frame_start} !== 10'd0) begin fails++; $display("FAIL async_rst_outputs got %h want 0", {if0.VGA_R, if0.VGA_G, if0.VGA_B, if0.pix_req, if0.frame_start}); end
    tests++; if (if0.frame_count !== 16'd0 || if1.frame_count !== 2'd0) begin fails++; $display("FAIL async_rst_fc got %0d/%0d want 0/0", if0.frame_count, if1.frame_count); end
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    starts = 0;
    while (starts < 4 && cnt < 1200) begin @(negedge clk); cnt++; starts += int'(if0.frame_start === 1'b1); end
    tests++; if (cnt != 4 * 224) begin fails++; $display("FAIL four_frames got clk %0d want 896", cnt); end
    tests++; if (if0.frame_count !== 16'd4) begin fails++; $display("FAIL fc16_after_4 got %0d want 4", if0.frame_count); end
    tests++; if (if1.frame_count !== 2'd0) begin fails++; $display("FAIL fc2_wrap got %0d want 0", if1.frame_count); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_en_toggle();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
